column_rasterizer: RTL and testbench
====================================

Name: column_rasterizer

Overview:
- Sits between the DDA-out FIFO and the frame buffer write port.
- Pops one column record per ray (hcount, line height, wall side, map cell type, wallX) and expands it into SCREEN_HEIGHT pixel writes: ceiling, then wall slice, then floor.
- Signals frame completion when the column flagged tlast has been fully written, so the frame buffer can swap.

Parameters:
- SCREEN_WIDTH, 320, columns per frame and row stride of the frame buffer address.
- SCREEN_HEIGHT, 240, pixels written per column.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT.
- CEIL_COLOR, 16'h2104, RGB565 ceiling colour.
- FLOOR_COLOR, 16'h4208, RGB565 floor colour.

Ports:
- pixel_clk_in  in  1  the single clock for the block.
- rst_in  in  1  synchronous, active-high reset.
- dda_fifo_tvalid_in  in  1  column record valid.
- dda_fifo_tdata_in  in  38  record: [37:29] hcount, [28:21] lineHeight, [20] wallType (1 = y-side), [19:16] mapData, [15:0] wallX (reserved, unused).
- dda_fifo_tlast_in  in  1  last column of the frame.
- rasterizer_tready_out  out  1  ready to accept a record.
- pixel_wr_en_out  out  1  write strobe to the frame buffer.
- pixel_addr_out  out  ADDR_W  write address, y*SCREEN_WIDTH + hcount.
- pixel_data_out  out  16  RGB565 pixel.
- frame_done_out  out  1  one-cycle pulse after the last write of the tlast column.

Behaviour:
- Reset values: rasterizer_tready_out=1, pixel_wr_en_out=0, pixel_addr_out=0, pixel_data_out=0, frame_done_out=0. State returns to IDLE.
- FSM states are IDLE, SETUP and DRAW.
- IDLE:
  - tready=1.
  - On tvalid&&tready, latch the record and tlast, then go to SETUP.
- SETUP (1 cycle, tready=0):
  - lh = min(lineHeight, SCREEN_HEIGHT); forced to 0 if mapData==0.
  - drawStart = (SCREEN_HEIGHT - lh) >> 1.
  - drawEnd = drawStart + lh - 1; wall is empty when lh==0.
  - Wall colour = WALL_PALETTE[mapData]. If wallType=1, each RGB565 field is shifted right by 1 (r>>1, g>>1, b>>1).
  - Address accumulator = hcount; y = 0.
  - Go to DRAW.
- DRAW (SCREEN_HEIGHT cycles, tready=0):
  - Each cycle: wr_en=1, addr=accumulator, data = CEIL_COLOR if y<drawStart, wall colour if drawStart<=y<=drawEnd, FLOOR_COLOR otherwise.
  - Then accumulator += SCREEN_WIDTH and y += 1. No multiplier is used.
  - After y==SCREEN_HEIGHT-1: go to IDLE. If the latched tlast=1, pulse frame_done_out on the cycle following the last write.
- Outputs are registered.
  - Latency: handshake at cycle 0, SETUP at cycle 1, first write visible at cycle 2, last write at cycle SCREEN_HEIGHT+1.
  - Throughput: one column per SCREEN_HEIGHT+2 cycles (242). 320 columns take 77,440 cycles, which is within one 720p frame.
- Boundary conditions:
  - hcount >= SCREEN_WIDTH: the record is accepted and no writes are made. If tlast=1, frame_done_out pulses 2 cycles after the handshake.
  - lineHeight >= SCREEN_HEIGHT: full-height wall, drawStart=0, drawEnd=SCREEN_HEIGHT-1.
  - Odd difference (SCREEN_HEIGHT - lh): the extra row goes to the floor.
  - tvalid low in IDLE: wr_en stays 0 and state holds.
  - Reset asserted mid-DRAW: the next cycle has IDLE and reset output values; the partial column is abandoned and no frame_done pulse is produced.
  - The frame buffer write port always accepts; the block has no output backpressure.

Decomposition:
- Package raycast_pkg holds:
  - column_rec_t packed struct matching the 38-bit layout.
  - rgb565_t.
  - WALL_PALETTE, a 16-entry RGB565 localparam array; entry 0 unused.
  - darken_565 function.
  - Screen size constants.
- Sub-module column_span_calc (combinational lineHeight→drawStart/drawEnd clamp), instantiated in SETUP.

Test Plan:
1. Record hcount=5, lineHeight=100, wallType=0, mapData=1, tlast=0 → 240 writes.
   - Addresses 5, 325, …, 76485.
   - y 0–69 CEIL_COLOR, y 70–169 WALL_PALETTE[1], y 170–239 FLOOR_COLOR.
   - No frame_done pulse.
2. Same record with wallType=1 and WALL_PALETTE[1]=16'hF800 → wall pixels 16'h7800.
3. lineHeight=255, hcount=319, tlast=1 → all 240 pixels wall.
   - Last address 76799.
   - frame_done_out high exactly one cycle after that write.
4. mapData=0, lineHeight=50 → 120 ceiling pixels then 120 floor pixels; no wall pixels.
5. hcount=400, tlast=1 → no wr_en, frame_done_out pulse at cycle 2; tready back high at cycle 2.
6. Back-to-back valid records plus rst_in pulsed at DRAW y=100 → tready low during SETUP/DRAW; after reset no further writes until a new handshake, and the second record is taken in IDLE.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycaster column pipeline: the DDA column
// record layout, RGB565 helpers and the wall colour palette.
package raycast_pkg;

    localparam int SCREEN_WIDTH_DEF  = 320;
    localparam int SCREEN_HEIGHT_DEF = 240;
    localparam int ADDR_W_DEF        = 17;

    typedef struct packed {
        logic [8:0]  hcount;
        logic [7:0]  line_height;
        logic        wall_type;
        logic [3:0]  map_data;
        logic [15:0] wall_x;
    } column_rec_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Indexed by map cell type; entry 0 is empty space and never drawn.
    localparam rgb565_t [15:0] WALL_PALETTE = {
        16'hB5B6, 16'h2945, 16'hC618, 16'h5AEB,
        16'hA145, 16'h841F, 16'hFC00, 16'h8410,
        16'h07FF, 16'hF81F, 16'hFFE0, 16'hFFFF,
        16'h001F, 16'h07E0, 16'hF800, 16'h0000
    };

    function automatic rgb565_t darken_565(input rgb565_t c);
        rgb565_t d;
        d.r = c.r >> 1;
        d.g = c.g >> 1;
        d.b = c.b >> 1;
        return d;
    endfunction

endpackage

// File: rtl/column_span_calc.sv
// Combinational wall span for one column: clamps the line height to the
// screen and centres it vertically.
module column_span_calc
    import raycast_pkg::*;
#(
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int Y_W           = $clog2(SCREEN_HEIGHT + 1)
) (
    input  logic [7:0]     line_height_in,
    input  logic [3:0]     map_data_in,
    output logic [Y_W-1:0] draw_start_out,
    output logic [Y_W-1:0] draw_end_out,
    output logic           wall_empty_out
);

    int lh_i;
    int ds_i;

    always_comb begin
        lh_i = int'(line_height_in);
        if (lh_i > SCREEN_HEIGHT) lh_i = SCREEN_HEIGHT;
        if (map_data_in == 4'd0)  lh_i = 0;
        // Truncating halve puts the odd leftover row on the floor side.
        ds_i           = (SCREEN_HEIGHT - lh_i) / 2;
        draw_start_out = Y_W'(ds_i);
        draw_end_out   = Y_W'(ds_i + lh_i - 1);
        wall_empty_out = (lh_i == 0);
    end

endmodule

// File: rtl/column_rasterizer.sv
// Expands one DDA column record into SCREEN_HEIGHT frame buffer writes
// (ceiling, wall slice, floor) and flags the end of a frame.
module column_rasterizer
    import raycast_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int          SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int          ADDR_W        = ADDR_W_DEF,
    parameter logic [15:0] CEIL_COLOR    = 16'h2104,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              dda_fifo_tvalid_in,
    input  logic [37:0]       dda_fifo_tdata_in,
    input  logic              dda_fifo_tlast_in,
    output logic              rasterizer_tready_out,
    output logic              pixel_wr_en_out,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic [15:0]       pixel_data_out,
    output logic              frame_done_out
);

    localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_e;

    column_rec_t rec_in;
    logic        unused_wall_x;
    assign rec_in        = column_rec_t'(dda_fifo_tdata_in);
    assign unused_wall_x = ^rec_in.wall_x;

    state_e            state_q, state_d;
    logic [8:0]        hcount_q, hcount_d;
    logic [7:0]        lh_q, lh_d;
    logic              wall_type_q, wall_type_d;
    logic [3:0]        map_q, map_d;
    logic              tlast_q, tlast_d;
    logic [Y_W-1:0]    ds_q, ds_d, de_q, de_d, y_q, y_d;
    logic              empty_q, empty_d;
    logic [15:0]       wall_q, wall_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic              tready_q, tready_d, wr_en_q, wr_en_d, done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;

    logic [Y_W-1:0]    span_ds, span_de;
    logic              span_empty;

    column_span_calc #(
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .Y_W           (Y_W)
    ) u_span (
        .line_height_in (lh_q),
        .map_data_in    (map_q),
        .draw_start_out (span_ds),
        .draw_end_out   (span_de),
        .wall_empty_out (span_empty)
    );

    function automatic logic [15:0] pixel_color(
        input logic [Y_W-1:0] y,
        input logic [Y_W-1:0] ds,
        input logic [Y_W-1:0] de,
        input logic           empty,
        input logic [15:0]    wall
    );
        if (y < ds)                return CEIL_COLOR;
        else if (!empty && y <= de) return wall;
        else                        return FLOOR_COLOR;
    endfunction

    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        lh_d        = lh_q;
        wall_type_d = wall_type_q;
        map_d       = map_q;
        tlast_d     = tlast_q;
        ds_d        = ds_q;
        de_d        = de_q;
        empty_d     = empty_q;
        wall_d      = wall_q;
        acc_d       = acc_q;
        y_d         = y_q;
        tready_d    = tready_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                tready_d = 1'b1;
                if (dda_fifo_tvalid_in && tready_q) begin
                    hcount_d    = rec_in.hcount;
                    lh_d        = rec_in.line_height;
                    wall_type_d = rec_in.wall_type;
                    map_d       = rec_in.map_data;
                    tlast_d     = dda_fifo_tlast_in;
                    tready_d    = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                ds_d    = span_ds;
                de_d    = span_de;
                empty_d = span_empty;
                wall_d  = wall_type_q ? darken_565(WALL_PALETTE[map_q]) : WALL_PALETTE[map_q];
                if (int'(hcount_q) >= SCREEN_WIDTH) begin
                    // Off-screen column: consume it silently but still honour tlast.
                    state_d  = IDLE;
                    tready_d = 1'b1;
                    done_d   = tlast_q;
                end else begin
                    // Row 0 is issued here so the write stream starts one cycle after SETUP.
                    state_d = DRAW;
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_W'(hcount_q);
                    data_d  = pixel_color('0, span_ds, span_de, span_empty, wall_d);
                    acc_d   = ADDR_W'(hcount_q) + ADDR_W'(SCREEN_WIDTH);
                    y_d     = Y_W'(1);
                end
            end
            DRAW: begin
                if (y_q == Y_W'(SCREEN_HEIGHT)) begin
                    state_d  = IDLE;
                    tready_d = 1'b1;
                    done_d   = tlast_q;
                end else begin
                    wr_en_d = 1'b1;
                    addr_d  = acc_q;
                    data_d  = pixel_color(y_q, ds_q, de_q, empty_q, wall_q);
                    acc_d   = acc_q + ADDR_W'(SCREEN_WIDTH);
                    y_d     = y_q + Y_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                tready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            hcount_q    <= '0;
            lh_q        <= '0;
            wall_type_q <= 1'b0;
            map_q       <= '0;
            tlast_q     <= 1'b0;
            ds_q        <= '0;
            de_q        <= '0;
            empty_q     <= 1'b1;
            wall_q      <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            tready_q    <= 1'b1;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcount_q    <= hcount_d;
            lh_q        <= lh_d;
            wall_type_q <= wall_type_d;
            map_q       <= map_d;
            tlast_q     <= tlast_d;
            ds_q        <= ds_d;
            de_q        <= de_d;
            empty_q     <= empty_d;
            wall_q      <= wall_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            tready_q    <= tready_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign rasterizer_tready_out = tready_q;
    assign pixel_wr_en_out       = wr_en_q;
    assign pixel_addr_out        = addr_q;
    assign pixel_data_out        = data_q;
    assign frame_done_out        = done_q;

endmodule

// File: tb/tb_column_rasterizer.sv
// Bench for column_rasterizer: directed vector table, randomized columns
// against a reference model, and a reset-during-draw sequence.
module tb_column_rasterizer;

    localparam int W     = 320;
    localparam int H     = 240;
    localparam int CEIL  = 16'h2104;
    localparam int FLOOR = 16'h4208;
    localparam int NCAP  = 244;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [37:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tready, wr_en, done;
    logic [16:0] addr;
    logic [15:0] data;

    column_rasterizer dut (
        .pixel_clk_in          (clk),
        .rst_in                (rst),
        .dda_fifo_tvalid_in    (tvalid),
        .dda_fifo_tdata_in     (tdata),
        .dda_fifo_tlast_in     (tlast),
        .rasterizer_tready_out (tready),
        .pixel_wr_en_out       (wr_en),
        .pixel_addr_out        (addr),
        .pixel_data_out        (data),
        .frame_done_out        (done)
    );

    always #5 clk = ~clk;

    int pal [16] = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'hFFE0,
                     16'hF81F, 16'h07FF, 16'h8410, 16'hFC00, 16'h841F, 16'hA145,
                     16'h5AEB, 16'hC618, 16'h2945, 16'hB5B6};

    int n_cmp = 0;
    int n_bad = 0;

    logic        cap_wr   [0:399];
    logic        cap_done [0:399];
    logic        cap_rdy  [0:399];
    logic [16:0] cap_addr [0:399];
    logic [15:0] cap_data [0:399];

    typedef struct {
        int hc, lh, wt, md, tl;
        int e_ceil, e_wall, e_floor, e_wall_color, e_writes, e_last_addr;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Spec-level picture of one column: centred wall of clamped height.
    function automatic int ref_pix(int y, int lh, int wt, int md);
        int h, top, c, r, g, b;
        h   = (md == 0) ? 0 : ((lh > H) ? H : lh);
        top = (H - h) / 2;
        if (y < top) return CEIL;
        if (y < top + h) begin
            c = pal[md];
            if (wt != 0) begin
                r = c / 2048; g = (c / 32) % 64; b = c % 32;
                c = (r / 2) * 2048 + (g / 2) * 32 + (b / 2);
            end
            return c;
        end
        return FLOOR;
    endfunction

    task automatic capture(input int c);
        cap_wr[c]   = wr_en;
        cap_done[c] = done;
        cap_rdy[c]  = tready;
        cap_addr[c] = addr;
        cap_data[c] = data;
    endtask

    task automatic present(input int hc, lh, wt, md, tl, output bit ok);
        int w;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = {9'(hc), 8'(lh), 1'(wt), 4'(md), 16'($urandom)};
        tlast  = 1'(tl);
        w = 0;
        while (!tready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = tready;
        if (!ok) begin
            chk("handshake_wait", 0, 1);
            tvalid = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic run_col(input int hc, lh, wt, md, tl, output bit ok);
        present(hc, lh, wt, md, tl, ok);
        if (ok) begin
            for (int c = 1; c <= NCAP; c++) begin
                @(negedge clk);
                if (c == 1) tvalid = 1'b0;
                capture(c);
            end
        end
    endtask

    task automatic check_model(input int hc, lh, wt, md, tl, input string tag);
        int perr, derr, rerr, first, dc;
        bit ew, bad;
        perr = 0; derr = 0; rerr = 0; first = -1;
        dc = (hc < W) ? H + 2 : 2;
        for (int c = 1; c <= NCAP; c++) begin
            ew = (hc < W) && c >= 2 && c <= H + 1;
            if (ew)
                bad = !cap_wr[c] || int'(cap_addr[c]) != (c - 2) * W + hc ||
                      int'(cap_data[c]) != ref_pix(c - 2, lh, wt, md);
            else
                bad = cap_wr[c];
            if (bad) begin
                perr++;
                if (first < 0) first = c;
            end
            if (cap_done[c] != (tl != 0 && c == dc)) derr++;
            if (cap_rdy[c] != (c >= dc)) rerr++;
        end
        chk($sformatf("%s_pixels(first_bad_cycle=%0d)", tag, first), perr, 0);
        chk({tag, "_frame_done"}, derr, 0);
        chk({tag, "_tready"}, rerr, 0);
    endtask

    initial begin
        vec_t vt [6];
        bit ok;
        int nc, nw, nf, nwr, last, errs;

        vt[0] = '{5,   100, 0, 1, 0, 70,  100, 70,  16'hF800, 240, 76485};
        vt[1] = '{5,   100, 1, 1, 0, 70,  100, 70,  16'h7800, 240, 76485};
        vt[2] = '{319, 255, 0, 2, 1, 0,   240, 0,   16'h07E0, 240, 76799};
        vt[3] = '{10,  50,  0, 0, 0, 120, 0,   120, 16'hFFFF, 240, 76490};
        vt[4] = '{400, 30,  0, 3, 1, 0,   0,   0,   16'h001F, 0,   0};
        vt[5] = '{100, 101, 0, 3, 0, 69,  101, 70,  16'h001F, 240, 76580};

        repeat (3) @(negedge clk);
        chk("reset_tready", tready, 1);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_addr", addr, 0);
        chk("reset_data", data, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;

        errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr_en || done || !tready) errs++;
        end
        chk("idle_no_activity", errs, 0);

        for (int i = 0; i < 6; i++) begin
            run_col(vt[i].hc, vt[i].lh, vt[i].wt, vt[i].md, vt[i].tl, ok);
            if (!ok) continue;
            nc = 0; nw = 0; nf = 0; nwr = 0; last = 0;
            for (int c = 1; c <= NCAP; c++) begin
                if (cap_wr[c]) begin
                    nwr++;
                    last = int'(cap_addr[c]);
                    if (int'(cap_data[c]) == CEIL) nc++;
                    else if (int'(cap_data[c]) == vt[i].e_wall_color) nw++;
                    else if (int'(cap_data[c]) == FLOOR) nf++;
                end
            end
            chk($sformatf("vec%0d_writes", i), nwr, vt[i].e_writes);
            chk($sformatf("vec%0d_ceil", i), nc, vt[i].e_ceil);
            chk($sformatf("vec%0d_wall", i), nw, vt[i].e_wall);
            chk($sformatf("vec%0d_floor", i), nf, vt[i].e_floor);
            chk($sformatf("vec%0d_last_addr", i), last, vt[i].e_last_addr);
            check_model(vt[i].hc, vt[i].lh, vt[i].wt, vt[i].md, vt[i].tl, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            int hc, lh, wt, md, tl;
            hc = $urandom_range(0, 335);
            lh = $urandom_range(0, 255);
            wt = $urandom_range(0, 1);
            md = $urandom_range(0, 15);
            tl = $urandom_range(0, 1);
            run_col(hc, lh, wt, md, tl, ok);
            if (ok) check_model(hc, lh, wt, md, tl, $sformatf("rnd%0d", i));
        end

        // Column A is cut short by reset at row 100; column B waits with tvalid high.
        present(7, 80, 0, 5, 1, ok);
        if (ok) begin
            for (int c = 1; c <= 346; c++) begin
                @(negedge clk);
                capture(c);
                if (c == 1) begin
                    tdata = {9'd12, 8'd200, 1'b1, 4'd9, 16'h0};
                    tlast = 1'b0;
                end
                if (c == 102) rst = 1'b1;
                if (c == 103) rst = 1'b0;
                if (c == 104) tvalid = 1'b0;
            end
            errs = 0;
            for (int c = 1; c <= 102; c++) if (cap_rdy[c]) errs++;
            chk("rst_seq_tready_low_while_busy", errs, 0);
            chk("rst_seq_row100_addr", cap_addr[102], 100 * W + 7);
            chk("rst_seq_row100_data", cap_data[102], ref_pix(100, 80, 0, 5));
            chk("rst_seq_after_reset_state",
                {cap_wr[103], cap_rdy[103], cap_addr[103], cap_data[103], cap_done[103]},
                {1'b0, 1'b1, 17'd0, 16'd0, 1'b0});
            chk("rst_seq_setup_b", {cap_wr[104], cap_rdy[104]}, 2'b00);
            errs = 0;
            for (int c = 1; c <= 346; c++) if (cap_done[c]) errs++;
            chk("rst_seq_no_frame_done", errs, 0);
            errs = 0;
            for (int c = 105; c <= 344; c++)
                if (!cap_wr[c] || int'(cap_addr[c]) != (c - 105) * W + 12 ||
                    int'(cap_data[c]) != ref_pix(c - 105, 200, 1, 9)) errs++;
            chk("rst_seq_column_b_pixels", errs, 0);
            chk("rst_seq_column_b_end", {cap_wr[345], cap_rdy[345]}, 2'b01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
